// File: rtl/uart_rx_cfg.sv
// UART receiver: programmable baud tick, optional even/odd parity, and a small FWFT FIFO
// that stores each received word with its parity and framing error flags.
module uart_rx_cfg #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     dvsr,
    input  logic [1:0]      parity_mode,
    input  logic            rx,
    input  logic            rd_uart,
    input  logic            err_clr,
    output logic [DBIT-1:0] r_data,
    output logic            r_perr,
    output logic            r_ferr,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            overrun_err,
    output logic [2:0]      o_dbg_state
);

    localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 2 ** FIFO_W;
    localparam int WW    = DBIT + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Baud tick generator; the >= compare lets a smaller dvsr take effect at once.
    logic [10:0] r_baud;
    logic        w_tick;

    assign w_tick = (dvsr != 11'd0) && (r_baud >= dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud <= 11'd0;
        end else if (r_baud >= dvsr) begin
            r_baud <= 11'd0;
        end else begin
            r_baud <= r_baud + 11'd1;
        end
    end

    logic r_sync1;
    logic r_sync2;
    logic w_rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    state_t          r_state;
    state_t          w_state_n;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_s_n;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_n_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] w_b_n;
    logic [1:0]      r_pmode;
    logic [1:0]      w_pmode_n;
    logic            r_perr_q;
    logic            w_perr_n;
    logic            w_wr;
    logic            w_ferr;
    logic            w_par_on;

    assign w_par_on = (r_pmode == 2'b01) || (r_pmode == 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_b      <= '0;
            r_pmode  <= 2'b00;
            r_perr_q <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_s      <= w_s_n;
            r_n      <= w_n_n;
            r_b      <= w_b_n;
            r_pmode  <= w_pmode_n;
            r_perr_q <= w_perr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_n_n     = r_n;
        w_b_n     = r_b;
        w_pmode_n = r_pmode;
        w_perr_n  = r_perr_q;
        w_wr      = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_state_n = START;
                    w_s_n     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!w_rx) begin
                            w_state_n = DATA;
                            w_s_n     = '0;
                            w_n_n     = '0;
                            w_pmode_n = parity_mode;
                            w_perr_n  = 1'b0;
                        end else begin
                            w_state_n = IDLE;
                        end
                    end else begin
                        w_s_n = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_s_n = '0;
                        w_b_n = {w_rx, r_b[DBIT-1:1]};
                        if (r_n == NW'(DBIT - 1)) begin
                            w_state_n = w_par_on ? PARITY : STOP;
                        end else begin
                            w_n_n = r_n + NW'(1);
                        end
                    end else begin
                        w_s_n = r_s + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        // Even mode flags odd total ones; odd mode flags even total ones.
                        w_perr_n  = (r_pmode == 2'b01) ? (^r_b ^ w_rx) : ~(^r_b ^ w_rx);
                        w_state_n = STOP;
                        w_s_n     = '0;
                    end else begin
                        w_s_n = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_wr      = 1'b1;
                        w_ferr    = ~w_rx;
                        w_state_n = IDLE;
                        w_s_n     = '0;
                    end else begin
                        w_s_n = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

    // FIFO handshake: a pop happens when rd_uart=1 and rx_empty=0; a write is accepted
    // when not full, or when full with a same-cycle pop, otherwise it is dropped as overrun.
    logic [WW-1:0]     r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wptr;
    logic [FIFO_W-1:0] r_rptr;
    logic [FIFO_W:0]   r_count;
    logic              r_ovr;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [WW-1:0]     w_wdata;
    logic [WW-1:0]     w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (FIFO_W + 1)'(DEPTH));
    assign w_pop   = rd_uart & ~w_empty;
    assign w_push  = w_wr & (~w_full | w_pop);
    assign w_wdata = {r_perr_q, w_ferr, r_b};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_W + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_wr && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end else if (err_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign r_data      = w_empty ? '0 : w_head[DBIT-1:0];
    assign r_ferr      = w_empty ? 1'b0 : w_head[DBIT];
    assign r_perr      = w_empty ? 1'b0 : w_head[DBIT+1];
    assign rx_empty    = w_empty;
    assign rx_full     = w_full;
    assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8-bit frames with and without parity, framing errors,
// glitch rejection, FIFO overrun and mid-frame reset, checked by immediate assertions.
module tb_uart_rx_cfg;
    logic        clk;
    logic        reset;
    logic [10:0] dvsr;
    logic [1:0]  parity_mode;
    logic        rx;
    logic        rd_uart;
    logic        err_clr;
    logic [7:0]  r_data;
    logic        r_perr;
    logic        r_ferr;
    logic        rx_empty;
    logic        rx_full;
    logic        overrun_err;
    logic [2:0]  o_dbg_state;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;
    int bclk;

    uart_rx_cfg #(.DBIT(8), .SB_TICK(16), .FIFO_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .dvsr        (dvsr),
        .parity_mode (parity_mode),
        .rx          (rx),
        .rd_uart     (rd_uart),
        .err_clr     (err_clr),
        .r_data      (r_data),
        .r_perr      (r_perr),
        .r_ferr      (r_ferr),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .overrun_err (overrun_err),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8-bit frame; a low stop bit is released early so it is not seen as a new start.
    task automatic send_frame(input logic [7:0] data, input bit use_par, input logic par_bit,
                              input logic stop_bit, input int b);
        rx = 1'b0;
        wait_clks(b);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(b);
        end
        if (use_par) begin
            rx = par_bit;
            wait_clks(b);
        end
        if (stop_bit) begin
            rx = 1'b1;
            wait_clks(b);
        end else begin
            rx = 1'b0;
            wait_clks((b * 3) / 4);
            rx = 1'b1;
            wait_clks(b - (b * 3) / 4);
        end
        rx = 1'b1;
        wait_clks(b);
    endtask

    task automatic pop;
        rd_uart = 1'b1;
        wait_clks(1);
        rd_uart = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        dvsr        = 11'd162;
        parity_mode = 2'b00;
        rx          = 1'b1;
        rd_uart     = 1'b0;
        err_clr     = 1'b0;
        wait_clks(4);
        check("rst_empty", 16'(rx_empty), 16'h1);
        check("rst_full", 16'(rx_full), 16'h0);
        check("rst_ovr", 16'(overrun_err), 16'h0);
        check("rst_data", 16'(r_data), 16'h0);
        check("rst_perr", 16'(r_perr), 16'h0);
        check("rst_ferr", 16'(r_ferr), 16'h0);
        check("rst_state", 16'(o_dbg_state), 16'h0);
        reset = 1'b0;
        wait_clks(4);

        bclk = 2608;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, bclk);
        check("a5_empty", 16'(rx_empty), 16'h0);
        check("a5_data", 16'(r_data), 16'hA5);
        check("a5_perr", 16'(r_perr), 16'h0);
        check("a5_ferr", 16'(r_ferr), 16'h0);
        pop();
        check("a5_pop_empty", 16'(rx_empty), 16'h1);
        check("a5_pop_data", 16'(r_data), 16'h0);

        rx = 1'b0;
        wait_clks(500);
        rx = 1'b1;
        wait_clks(3000);
        check("glitch_empty", 16'(rx_empty), 16'h1);
        check("glitch_state", 16'(o_dbg_state), 16'h0);

        dvsr = 11'd4;
        bclk = 80;
        wait_clks(20);
        parity_mode = 2'b01;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, bclk);
        check("even_p0_data", 16'(r_data), 16'h07);
        check("even_p0_perr", 16'(r_perr), 16'h1);
        pop();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, bclk);
        check("even_p1_data", 16'(r_data), 16'h07);
        check("even_p1_perr", 16'(r_perr), 16'h0);
        pop();
        parity_mode = 2'b10;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, bclk);
        check("odd_p0_perr", 16'(r_perr), 16'h0);
        check("odd_p0_ferr", 16'(r_ferr), 16'h0);
        pop();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, bclk);
        check("odd_p1_perr", 16'(r_perr), 16'h1);
        pop();
        parity_mode = 2'b11;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, bclk);
        check("mode3_data", 16'(r_data), 16'h96);
        check("mode3_perr", 16'(r_perr), 16'h0);
        check("mode3_ferr", 16'(r_ferr), 16'h0);
        pop();
        check("mode3_empty", 16'(rx_empty), 16'h1);

        parity_mode = 2'b00;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, bclk);
        wait_clks(400);
        check("ferr_data", 16'(r_data), 16'h3C);
        check("ferr_flag", 16'(r_ferr), 16'h1);
        check("ferr_perr", 16'(r_perr), 16'h0);
        check("ferr_state", 16'(o_dbg_state), 16'h0);
        pop();
        check("ferr_single", 16'(rx_empty), 16'h1);

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, bclk);
        end
        check("ovr_full", 16'(rx_full), 16'h1);
        check("ovr_flag", 16'(overrun_err), 16'h1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_rd%0d", i), 16'(r_data), 16'(i));
            pop();
            check($sformatf("ovr_full_after%0d", i), 16'(rx_full), 16'h0);
        end
        check("ovr_drain_empty", 16'(rx_empty), 16'h1);
        check("ovr_sticky", 16'(overrun_err), 16'h1);
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
        check("ovr_clr", 16'(overrun_err), 16'h0);

        send_frame(8'h11, 1'b0, 1'b0, 1'b1, bclk);
        check("pre_rst_empty", 16'(rx_empty), 16'h0);
        rx = 1'b0;
        wait_clks(bclk);
        rx = 1'b1;
        wait_clks(bclk);
        rx = 1'b0;
        wait_clks(bclk);
        rx = 1'b1;
        wait_clks(bclk / 2);
        check("mid_state_data", 16'(o_dbg_state), 16'h2);
        reset = 1'b1;
        wait_clks(3);
        check("mid_rst_empty", 16'(rx_empty), 16'h1);
        check("mid_rst_state", 16'(o_dbg_state), 16'h0);
        reset = 1'b0;
        rx = 1'b1;
        wait_clks(2 * bclk);
        check("post_rst_idle_empty", 16'(rx_empty), 16'h1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, bclk);
        check("post_rst_data", 16'(r_data), 16'h5A);
        check("post_rst_ferr", 16'(r_ferr), 16'h0);
        pop();
        check("post_rst_only", 16'(rx_empty), 16'h1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
